// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: registered RV32 instruction decode stage for the barrel core.
// Decode is combinational on in_instr; records land in a main output register backed by one skid entry.
module rv32_decode_stage #(
  parameter int XPR_LEN        = 32,
  parameter int HART_CNT_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XPR_LEN-1:0]        in_instr,
  input  logic [XPR_LEN-1:0]        in_pc,
  input  logic [HART_CNT_WIDTH-1:0] in_hart,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                out_opcode,
  output logic [5:0]                out_type,
  output logic [XPR_LEN-1:0]        out_imm,
  output logic [11:0]               out_csr,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [4:0]                out_rd,
  output logic [XPR_LEN-1:0]        out_pc,
  output logic [HART_CNT_WIDTH-1:0] out_hart,
  output logic                      out_illegal
);

  localparam logic [5:0] T_R = 6'b100000, T_I = 6'b010000, T_S = 6'b001000, T_B = 6'b000100,
                         T_U = 6'b000010, T_J = 6'b000001, T_NOP = 6'b000000, T_UNK = 6'b111111;

  localparam logic [5:0] OP_LB = 6'd0, OP_LH = 6'd1, OP_LW = 6'd2, OP_LBU = 6'd3, OP_LHU = 6'd4,
    OP_SB = 6'd5, OP_SH = 6'd6, OP_SW = 6'd7, OP_SLL = 6'd8, OP_SLLI = 6'd9, OP_SRL = 6'd10,
    OP_SRLI = 6'd11, OP_SRA = 6'd12, OP_SRAI = 6'd13, OP_ADD = 6'd14, OP_ADDI = 6'd15,
    OP_SUB = 6'd16, OP_LUI = 6'd17, OP_AUIPC = 6'd18, OP_XOR = 6'd19, OP_XORI = 6'd20,
    OP_OR = 6'd21, OP_ORI = 6'd22, OP_AND = 6'd23, OP_ANDI = 6'd24, OP_SLT = 6'd25,
    OP_SLTI = 6'd26, OP_SLTU = 6'd27, OP_SLTIU = 6'd28, OP_BEQ = 6'd29, OP_BNE = 6'd30,
    OP_BLT = 6'd31, OP_BGE = 6'd32, OP_BLTU = 6'd33, OP_BGEU = 6'd34, OP_JAL = 6'd35,
    OP_JALR = 6'd36, OP_FENCE = 6'd37, OP_FENCEI = 6'd38, OP_CSRRW = 6'd39, OP_CSRRS = 6'd40,
    OP_CSRRC = 6'd41, OP_CSRRWI = 6'd42, OP_CSRRSI = 6'd43, OP_CSRRCI = 6'd44, OP_ECALL = 6'd45,
    OP_EBREAK = 6'd46, OP_ERET = 6'd47, OP_WFI = 6'd48, OP_MRET = 6'd49, OP_NOP = 6'd50,
    OP_UNK = 6'd63;

  typedef struct packed {
    logic [5:0]                opcode;
    logic [5:0]                fmt;
    logic [XPR_LEN-1:0]        imm;
    logic [11:0]               csr;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [4:0]                rd;
    logic [XPR_LEN-1:0]        pc;
    logic [HART_CNT_WIDTH-1:0] hart;
    logic                      illegal;
  } rec_t;

  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [XPR_LEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_z;
  logic [5:0]         raw_op, raw_type;
  logic [XPR_LEN-1:0] raw_imm;
  logic [11:0]        raw_csr;
  logic [4:0]         raw_rs1, raw_rs2, raw_rd;
  logic               is_nop, illegal, accept;
  rec_t               dec, main_rec, skid_rec;
  logic               main_valid, skid_valid;

  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{(XPR_LEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XPR_LEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XPR_LEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'h000};
  assign imm_j  = {{(XPR_LEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_sh = {{(XPR_LEN-5){1'b0}}, in_instr[24:20]};
  assign imm_z  = {{(XPR_LEN-5){1'b0}}, in_instr[19:15]};

  // Raw decode: defaults describe an I-format word; each major opcode overrides what differs.
  always_comb begin
    raw_op   = OP_UNK;
    raw_type = T_I;
    raw_imm  = imm_i;
    raw_csr  = 12'h000;
    raw_rs1  = in_instr[19:15];
    raw_rs2  = 5'd0;
    raw_rd   = in_instr[11:7];
    case (in_instr[6:0])
      7'h03: begin
        case (f3)
          3'd0: raw_op = OP_LB;
          3'd1: raw_op = OP_LH;
          3'd2: raw_op = OP_LW;
          3'd4: raw_op = OP_LBU;
          3'd5: raw_op = OP_LHU;
          default: raw_op = OP_UNK;
        endcase
      end
      7'h23: begin
        raw_type = T_S;
        raw_imm  = imm_s;
        raw_rs2  = in_instr[24:20];
        raw_rd   = 5'd0;
        case (f3)
          3'd0: raw_op = OP_SB;
          3'd1: raw_op = OP_SH;
          3'd2: raw_op = OP_SW;
          default: raw_op = OP_UNK;
        endcase
      end
      7'h13: begin
        case (f3)
          3'd0: raw_op = OP_ADDI;
          3'd2: raw_op = OP_SLTI;
          3'd3: raw_op = OP_SLTIU;
          3'd4: raw_op = OP_XORI;
          3'd6: raw_op = OP_ORI;
          3'd7: raw_op = OP_ANDI;
          3'd1: begin
            raw_imm = imm_sh;
            raw_op  = (f7 == 7'h00) ? OP_SLLI : OP_UNK;
          end
          3'd5: begin
            raw_imm = imm_sh;
            raw_op  = (f7 == 7'h00) ? OP_SRLI : ((f7 == 7'h20) ? OP_SRAI : OP_UNK);
          end
          default: raw_op = OP_UNK;
        endcase
      end
      7'h33: begin
        raw_type = T_R;
        raw_imm  = '0;
        raw_rs2  = in_instr[24:20];
        case ({f7, f3})
          10'h000: raw_op = OP_ADD;
          10'h001: raw_op = OP_SLL;
          10'h002: raw_op = OP_SLT;
          10'h003: raw_op = OP_SLTU;
          10'h004: raw_op = OP_XOR;
          10'h005: raw_op = OP_SRL;
          10'h006: raw_op = OP_OR;
          10'h007: raw_op = OP_AND;
          10'h100: raw_op = OP_SUB;
          10'h105: raw_op = OP_SRA;
          default: raw_op = OP_UNK;
        endcase
      end
      7'h37, 7'h17: begin
        raw_type = T_U;
        raw_imm  = imm_u;
        raw_rs1  = 5'd0;
        raw_op   = in_instr[5] ? OP_LUI : OP_AUIPC;
      end
      7'h6F: begin
        raw_type = T_J;
        raw_imm  = imm_j;
        raw_rs1  = 5'd0;
        raw_op   = OP_JAL;
      end
      7'h67: raw_op = (f3 == 3'd0) ? OP_JALR : OP_UNK;
      7'h63: begin
        raw_type = T_B;
        raw_imm  = imm_b;
        raw_rs2  = in_instr[24:20];
        raw_rd   = 5'd0;
        case (f3)
          3'd0: raw_op = OP_BEQ;
          3'd1: raw_op = OP_BNE;
          3'd4: raw_op = OP_BLT;
          3'd5: raw_op = OP_BGE;
          3'd6: raw_op = OP_BLTU;
          3'd7: raw_op = OP_BGEU;
          default: raw_op = OP_UNK;
        endcase
      end
      7'h0F: raw_op = (f3 == 3'd0) ? OP_FENCE : ((f3 == 3'd1) ? OP_FENCEI : OP_UNK);
      7'h73: begin
        // The 12 upper bits of a CSR op are an address, not an immediate, so imm stays 0.
        raw_imm = '0;
        raw_csr = in_instr[31:20];
        case (f3)
          3'd0: begin
            raw_csr = 12'h000;
            case (in_instr)
              32'h0000_0073: raw_op = OP_ECALL;
              32'h0010_0073: raw_op = OP_EBREAK;
              32'h0020_0073: raw_op = OP_ERET;
              32'h1050_0073: raw_op = OP_WFI;
              32'h3020_0073: raw_op = OP_MRET;
              default:       raw_op = OP_UNK;
            endcase
          end
          3'd1: raw_op = OP_CSRRW;
          3'd2: raw_op = OP_CSRRS;
          3'd3: raw_op = OP_CSRRC;
          3'd5: begin raw_op = OP_CSRRWI; raw_imm = imm_z; raw_rs1 = 5'd0; end
          3'd6: begin raw_op = OP_CSRRSI; raw_imm = imm_z; raw_rs1 = 5'd0; end
          3'd7: begin raw_op = OP_CSRRCI; raw_imm = imm_z; raw_rs1 = 5'd0; end
          default: raw_op = OP_UNK;
        endcase
      end
      default: raw_op = OP_UNK;
    endcase
  end

  assign is_nop  = (in_instr == 32'h0000_0013);
  assign illegal = (raw_op == OP_UNK);

  // Record assembly: illegal words keep only pc/hart, the canonical NOP gets all-zero fields.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.hart    = in_hart;
    dec.illegal = illegal;
    dec.opcode  = is_nop ? OP_NOP : raw_op;
    if (illegal) begin
      dec.fmt = T_UNK;
    end else if (is_nop) begin
      dec.fmt = T_NOP;
    end else begin
      dec.fmt = raw_type;
      dec.imm = raw_imm;
      dec.csr = raw_csr;
      dec.rs1 = raw_rs1;
      dec.rs2 = raw_rs2;
      dec.rd  = raw_rd;
    end
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;

  // Main/skid storage: skid only fills while main is stalled, and drains into main first.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_rec   <= '0;
      skid_rec   <= '0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_rec   <= skid_rec;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_rec   <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_rec   <= dec;
      skid_valid <= 1'b1;
    end else begin
      skid_valid <= skid_valid;
    end
  end

  assign out_valid   = main_valid;
  assign out_opcode  = main_rec.opcode;
  assign out_type    = main_rec.fmt;
  assign out_imm     = main_rec.imm;
  assign out_csr     = main_rec.csr;
  assign out_rs1     = main_rec.rs1;
  assign out_rs2     = main_rec.rs2;
  assign out_rd      = main_rec.rd;
  assign out_pc      = main_rec.pc;
  assign out_hart    = main_rec.hart;
  assign out_illegal = main_rec.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// tb_rv32_decode_stage: directed and random stimulus; a negedge monitor scores every output
// transfer against a mask/match instruction-table model held in a queue.
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [2:0]  in_hart, out_hart;
  logic [5:0]  out_opcode, out_type;
  logic [11:0] out_csr;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  always #5 clk = ~clk;

  rv32_decode_stage #(.XPR_LEN(32), .HART_CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_hart(in_hart), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_type(out_type), .out_imm(out_imm),
    .out_csr(out_csr), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_pc(out_pc), .out_hart(out_hart), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  fmt;
    logic [31:0] imm;
    logic [11:0] csr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [2:0]  hart;
    logic        illegal;
  } rec_t;

  localparam int K_R = 0, K_I = 1, K_SH = 2, K_S = 3, K_B = 4, K_U = 5, K_J = 6,
                 K_CSR = 7, K_CSRI = 8, K_SYS = 9, K_NOP = 10;

  // Instruction table indexed by opcode code (LB=0 .. NOP=50).
  localparam logic [31:0] MATCH [51] = '{
    32'h00000003, 32'h00001003, 32'h00002003, 32'h00004003, 32'h00005003,
    32'h00000023, 32'h00001023, 32'h00002023,
    32'h00001033, 32'h00001013, 32'h00005033, 32'h00005013, 32'h40005033, 32'h40005013,
    32'h00000033, 32'h00000013, 32'h40000033, 32'h00000037, 32'h00000017,
    32'h00004033, 32'h00004013, 32'h00006033, 32'h00006013, 32'h00007033, 32'h00007013,
    32'h00002033, 32'h00002013, 32'h00003033, 32'h00003013,
    32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063, 32'h00006063, 32'h00007063,
    32'h0000006F, 32'h00000067, 32'h0000000F, 32'h0000100F,
    32'h00001073, 32'h00002073, 32'h00003073, 32'h00005073, 32'h00006073, 32'h00007073,
    32'h00000073, 32'h00100073, 32'h00200073, 32'h10500073, 32'h30200073, 32'h00000013};
  localparam int KIND [51] = '{
    K_I, K_I, K_I, K_I, K_I, K_S, K_S, K_S,
    K_R, K_SH, K_R, K_SH, K_R, K_SH, K_R, K_I, K_R, K_U, K_U,
    K_R, K_I, K_R, K_I, K_R, K_I, K_R, K_I, K_R, K_I,
    K_B, K_B, K_B, K_B, K_B, K_B, K_J, K_I, K_I, K_I,
    K_CSR, K_CSR, K_CSR, K_CSRI, K_CSRI, K_CSRI,
    K_SYS, K_SYS, K_SYS, K_SYS, K_SYS, K_NOP};

  rec_t exp_q[$];
  rec_t got, exp_r;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] kind_mask(input int k);
    case (k)
      K_R, K_SH:    return 32'hFE00707F;
      K_U, K_J:     return 32'h0000007F;
      K_SYS, K_NOP: return 32'hFFFFFFFF;
      default:      return 32'h0000707F;
    endcase
  endfunction

  function automatic rec_t model(input logic [31:0] w, input logic [31:0] pc, input logic [2:0] h);
    rec_t r;
    int   code;
    int   v;
    r = '0;
    r.pc = pc;
    r.hart = h;
    code = 63;
    if (w == MATCH[50]) code = 50;
    else for (int i = 0; i < 50; i++)
      if (code == 63 && (w & kind_mask(KIND[i])) == MATCH[i]) code = i;
    r.opcode = code[5:0];
    if (code == 63) begin
      r.fmt = 6'b111111;
      r.illegal = 1'b1;
      return r;
    end
    r.fmt = 6'b010000;
    case (KIND[code])
      K_R: begin r.fmt = 6'b100000; r.rd = w[11:7]; r.rs1 = w[19:15]; r.rs2 = w[24:20]; end
      K_I: begin
        v = {20'd0, w[31:20]};
        if (v >= 2048) v = v - 4096;
        r.imm = v; r.rd = w[11:7]; r.rs1 = w[19:15];
      end
      K_SH: begin r.imm = {27'd0, w[24:20]}; r.rd = w[11:7]; r.rs1 = w[19:15]; end
      K_S: begin
        v = {20'd0, w[31:25], w[11:7]};
        if (v >= 2048) v = v - 4096;
        r.fmt = 6'b001000; r.imm = v; r.rs1 = w[19:15]; r.rs2 = w[24:20];
      end
      K_B: begin
        v = {19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (v >= 4096) v = v - 8192;
        r.fmt = 6'b000100; r.imm = v; r.rs1 = w[19:15]; r.rs2 = w[24:20];
      end
      K_U: begin r.fmt = 6'b000010; r.imm = w & 32'hFFFFF000; r.rd = w[11:7]; end
      K_J: begin
        v = {11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0};
        if (v >= 1048576) v = v - 2097152;
        r.fmt = 6'b000001; r.imm = v; r.rd = w[11:7];
      end
      K_CSR:  begin r.csr = w[31:20]; r.rd = w[11:7]; r.rs1 = w[19:15]; end
      K_CSRI: begin r.csr = w[31:20]; r.rd = w[11:7]; r.imm = {27'd0, w[19:15]}; end
      K_SYS:  r.fmt = 6'b010000;
      default: r.fmt = 6'b000000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    int i;
    if ($urandom_range(0, 3) == 0) return $urandom();
    i = $urandom_range(0, 50);
    return ($urandom() & ~kind_mask(KIND[i])) | MATCH[i];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: occupancy checks, then pop-and-compare on output transfer, then push on input transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check("occ_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check("occ_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (out_valid && out_ready) begin
        got.opcode = out_opcode; got.fmt = out_type; got.imm = out_imm; got.csr = out_csr;
        got.rs1 = out_rs1; got.rs2 = out_rs2; got.rd = out_rd; got.pc = out_pc;
        got.hart = out_hart; got.illegal = out_illegal;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h expected nothing", got);
        end else begin
          exp_r = exp_q.pop_front();
          if (got !== exp_r) begin
            n_fail++;
            $display("FAIL record pc=%h: got %h expected %h", exp_r.pc, got, exp_r);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc, in_hart));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc, input logic [2:0] h);
    logic hs;
    hs = 1'b0;
    in_valid = 1'b1; in_instr = w; in_pc = pc; in_hart = h;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clk);
      hs = in_ready;
      step();
    end
    if (!hs) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles (pc %h)", pc);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [31:0] w, input logic [5:0] op, input logic [5:0] typ);
    send(w, $urandom(), 3'($urandom_range(0, 7)));
    @(negedge clk);
    check("dir_valid", 64'(out_valid), 64'd1);
    check("dir_opcode", 64'(out_opcode), 64'(op));
    check("dir_type", 64'(out_type), 64'(typ));
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      step();
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    in_hart = 3'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_opcode", 64'(out_opcode), 64'd0);
    check("rst_imm", 64'(out_imm), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    step();

    // addi x1,x0,5 with one-cycle latency
    out_ready = 1'b1;
    send(32'h00500093, 32'h10, 3'd2);
    @(negedge clk);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_opcode", 64'(out_opcode), 64'd15);
    check("addi_type", 64'(out_type), 64'h10);
    check("addi_rd", 64'(out_rd), 64'd1);
    check("addi_rs1", 64'(out_rs1), 64'd0);
    check("addi_imm", 64'(out_imm), 64'd5);
    check("addi_pc", 64'(out_pc), 64'h10);
    check("addi_hart", 64'(out_hart), 64'd2);
    step();

    send_chk(32'hFE208EE3, 6'd29, 6'b000100);
    check("beq_rs1", 64'(out_rs1), 64'd1);
    check("beq_rs2", 64'(out_rs2), 64'd2);
    check("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    step();
    send_chk(32'h123450B7, 6'd17, 6'b000010);
    check("lui_imm", 64'(out_imm), 64'h12345000);
    step();
    send_chk(32'h30029073, 6'd39, 6'b010000);
    check("csrrw_csr", 64'(out_csr), 64'h300);
    check("csrrw_rs1", 64'(out_rs1), 64'd5);
    step();
    send_chk(32'h3002D073, 6'd42, 6'b010000);
    check("csrrwi_imm", 64'(out_imm), 64'd5);
    check("csrrwi_rs1", 64'(out_rs1), 64'd0);
    step();
    send_chk(32'h00000000, 6'd63, 6'b111111);
    check("zero_illegal", 64'(out_illegal), 64'd1);
    step();
    send_chk(32'h00000013, 6'd50, 6'b000000);
    check("nop_illegal", 64'(out_illegal), 64'd0);
    step();
    send_chk(32'hFFFFFFFF, 6'd63, 6'b111111);
    step();
    send_chk(32'h10500073, 6'd48, 6'b010000);
    check("wfi_imm", 64'(out_imm), 64'd0);
    step();

    // Back-pressure: A to main, B to skid, C held upstream
    out_ready = 1'b0;
    send(32'h002081B3, 32'h100, 3'd1);
    send(32'h402081B3, 32'h104, 3'd1);
    in_valid = 1'b1; in_instr = 32'h0020C1B3; in_pc = 32'h108; in_hart = 3'd1;
    repeat (2) begin
      @(negedge clk);
      check("skid_in_ready", 64'(in_ready), 64'd0);
      check("skid_out_valid", 64'(out_valid), 64'd1);
      check("skid_head_pc", 64'(out_pc), 64'h100);
      step();
    end
    out_ready = 1'b1;
    send(32'h0020C1B3, 32'h108, 3'd1);
    wait_drain();

    // Flush with both entries full and an input waiting
    out_ready = 1'b0;
    send(32'h00100113, 32'h200, 3'd3);
    send(32'h00200113, 32'h204, 3'd3);
    in_valid = 1'b1; in_instr = 32'h00300113; in_pc = 32'h208; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_full_out_valid", 64'(out_valid), 64'd0);
    check("flush_full_in_ready", 64'(in_ready), 64'd1);
    step();

    // Flush while an input is actually handshaking: that input must vanish
    send(32'h00400113, 32'h300, 3'd4);
    in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h308; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_hs_out_valid", 64'(out_valid), 64'd0);
    check("flush_hs_in_ready", 64'(in_ready), 64'd1);
    repeat (4) step();

    // Reset in the middle of back-pressure
    out_ready = 1'b0;
    send(32'h00600113, 32'h400, 3'd5);
    send(32'h00700113, 32'h404, 3'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_pc", 64'(out_pc), 64'd0);
    step();

    // Random traffic with back-pressure, flushes and occasional resets
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      in_pc     = $urandom();
      in_hart   = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
Registered instruction-decode pipeline stage between the per-hart fetch unit and the operand-read/execute stage of the barrel core. It accepts one raw 32-bit instruction per cycle, tagged with PC and hart ID, over a valid/ready handshake. It produces the decoded record: custom opcode code, instruction-format code, sign-extended immediate, CSR address and register fields. A two-entry skid buffer absorbs downstream back-pressure without dropping or duplicating instructions, and a flush clears the stage.

Parameters:
XPR_LEN, 32, datapath/instruction width.
HART_CNT_WIDTH, 3, hart ID width (8 harts).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  drop all held/incoming instructions this cycle
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_instr  in  XPR_LEN  raw instruction
in_pc  in  XPR_LEN  instruction PC
in_hart  in  HART_CNT_WIDTH  issuing hart
out_valid  out  1  decoded record valid
out_ready  in  1  downstream accepts
out_opcode  out  6  custom opcode code
out_type  out  6  format code
out_imm  out  XPR_LEN  decoded immediate
out_csr  out  12  CSR address (instr[31:20] for SYSTEM CSR ops, else 0)
out_rs1 / out_rs2 / out_rd  out  5 each  register fields (0 when unused by format)
out_pc  out  XPR_LEN  passthrough
out_hart  out  HART_CNT_WIDTH  passthrough
out_illegal  out  1  opcode decoded as UNKNOWN

Behaviour:
- Reset: out_valid=0, in_ready=1; all data outputs 0; skid entry empty.
- Transfer on in_valid&in_ready (input) and out_valid&out_ready (output).
- Latency 1 cycle: an instruction accepted at edge N appears on the outputs after edge N, i.e. in cycle N+1. Decode is combinational on in_instr, registered into the main entry.
- Skid: if main is valid, is not being consumed, and a new input arrives, the new decoded record goes to the skid entry. in_ready = !skid_valid (registered, no combinational path from out_ready). When main drains, skid moves to main on the same edge. Order is strictly preserved.
- Simultaneous accept and drain with skid empty: main is replaced by the new record, and out_valid stays 1.
- flush (highest priority after rst): main and skid are cleared, out_valid=0 next cycle, and any input handshaked in the same cycle is discarded. in_ready=1 next cycle.
- Opcode codes, 0..50 in this order: LB LH LW LBU LHU SB SH SW SLL SLLI SRL SRLI SRA SRAI ADD ADDI SUB LUI AUIPC XOR XORI OR ORI AND ANDI SLT SLTI SLTU SLTIU BEQ BNE BLT BGE BLTU BGEU JAL JALR FENCE FENCEI CSRRW CSRRS CSRRC CSRRWI CSRRSI CSRRCI ECALL EBREAK ERET WFI MRET NOP. UNKNOWN is 63.
- Type codes: R=6'b100000, I=6'b010000, S=6'b001000, B=6'b000100, U=6'b000010, J=6'b000001, NOP=0, UNKNOWN=6'b111111.
- Immediates:
  - I, S, B and J formats are sign-extended from the instruction sign bit; B and J have bit0=0.
  - U format is {instr[31:12],12'b0}.
  - SLLI/SRLI/SRAI use zero-extended shamt.
  - CSRR*I put zero-extended zimm (instr[19:15]) in imm, with rs1=0.
  - R format gives imm=0.
- NOP: exactly 32'h00000013 gives opcode NOP, type NOP, all fields 0.
- SYSTEM encodings:
  - ECALL 32'h00000073, EBREAK 32'h00100073, ERET 32'h00200073, WFI 32'h10500073, MRET 32'h30200073.
  - These are type I with imm=0 and csr=0.
  - Any other funct3=0 SYSTEM word is UNKNOWN.
- FENCE is opcode 7'h0F with funct3=0; FENCEI is funct3=1.
- Illegal: bad opcode, funct3 or funct7 (including 32'h0 and 32'hFFFFFFFF) gives opcode 63, type 6'b111111, out_illegal=1. The record still flows with its pc and hart.
- Reset or flush mid-backpressure loses both held entries, with no partial outputs.

Test Plan:
- rst, then in_instr=32'h00500093 (addi x1,x0,5), pc=0x10, hart=2, out_ready=1 -> next cycle out_valid=1, opcode=15, type=6'b010000, rd=1, rs1=0, imm=5, pc=0x10, hart=2.
- 32'hFE208EE3 (beq x1,x2,-4) -> opcode 29, type 6'b000100, rs1=1, rs2=2, imm=32'hFFFFFFFC; 32'h123450B7 (lui) -> opcode 17, imm=32'h12345000.
- 32'h30029073 (csrrw x0,mstatus,t0) -> opcode 39, csr=12'h300, rs1=5; 32'h3002D073 (csrrwi) -> opcode 42, imm=5, rs1=0.
- Hold out_ready=0 and send 3 back-to-back instrs A, B, C -> A accepted, B in skid, in_ready=0, C held upstream. Then release out_ready -> outputs A, B, C in order, with no loss or duplicates.
- flush asserted with both entries full while in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed input never appears.
- 32'h00000000 and 32'h00000013 -> first gives out_illegal=1, opcode 63; second gives opcode 50, type 0, out_illegal=0.
